// File: rtl/func_cycle_profiler.sv
// Per-function cycle/entry profiler fed by the PC-to-function lookup stage.
// Accumulates counts while idle and streams the table out over valid/ready on request.
module func_cycle_profiler #(
  parameter int unsigned NUM_FUNCS     = 64,
  parameter int unsigned IDX_W         = 6,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned CLEAR_ON_DUMP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fn_valid,
  input  logic [IDX_W-1:0] fn_idx,
  input  logic             dump_req,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [CNT_W-1:0] dump_cycles,
  output logic [CNT_W-1:0] dump_entries,
  output logic [CNT_W-1:0] oor_count,
  output logic             busy,
  output logic             dump_done
);

  localparam int unsigned AW = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FUNCS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycles_q  [NUM_FUNCS];
  logic [CNT_W-1:0] cycles_d  [NUM_FUNCS];
  logic [CNT_W-1:0] entries_q [NUM_FUNCS];
  logic [CNT_W-1:0] entries_d [NUM_FUNCS];
  logic [CNT_W-1:0] oor_q, oor_d;
  logic             last_vld_q, last_vld_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             dump_valid_q, dump_valid_d;
  logic [IDX_W-1:0] dump_idx_q, dump_idx_d;
  logic [CNT_W-1:0] dump_cycles_q, dump_cycles_d;
  logic [CNT_W-1:0] dump_entries_q, dump_entries_d;
  logic             busy_q, busy_d;
  logic             dump_done_q, dump_done_d;

  logic             in_range;
  logic [AW-1:0]    fn_a;

  assign in_range = 32'(fn_idx) < NUM_FUNCS;
  assign fn_a     = AW'(fn_idx);

  // Next-state, counter update and dump beat selection.
  always_comb begin
    state_d        = state_q;
    cycles_d       = cycles_q;
    entries_d      = entries_q;
    oor_d          = oor_q;
    last_vld_d     = last_vld_q;
    last_idx_d     = last_idx_q;
    ptr_d          = ptr_q;
    dump_valid_d   = dump_valid_q;
    dump_idx_d     = dump_idx_q;
    dump_cycles_d  = dump_cycles_q;
    dump_entries_d = dump_entries_q;
    dump_done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fn_valid) begin
          if (in_range) begin
            if (cycles_d[fn_a] != CNT_MAX) cycles_d[fn_a] = cycles_d[fn_a] + CNT_W'(1);
            if ((!last_vld_q || fn_idx != last_idx_q) && entries_d[fn_a] != CNT_MAX)
              entries_d[fn_a] = entries_d[fn_a] + CNT_W'(1);
            last_idx_d = fn_idx;
            last_vld_d = 1'b1;
          end else begin
            if (oor_d != CNT_MAX) oor_d = oor_d + CNT_W'(1);
            last_vld_d = 1'b0;
          end
        end
        // Beat 0 must reflect a sample counted in this same cycle.
        if (dump_req) begin
          state_d        = ST_DUMP;
          ptr_d          = '0;
          dump_valid_d   = 1'b1;
          dump_idx_d     = '0;
          dump_cycles_d  = cycles_d[AW'(0)];
          dump_entries_d = entries_d[AW'(0)];
        end
      end
      ST_DUMP: begin
        if (dump_valid_q && dump_ready) begin
          if (ptr_q == LAST_IDX) begin
            dump_valid_d = 1'b0;
            dump_done_d  = 1'b1;
            state_d      = ST_DONE;
          end else begin
            ptr_d          = ptr_q + IDX_W'(1);
            dump_idx_d     = ptr_d;
            dump_cycles_d  = cycles_q[AW'(ptr_d)];
            dump_entries_d = entries_q[AW'(ptr_d)];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (CLEAR_ON_DUMP != 0) begin
          cycles_d   = '{default: '0};
          entries_d  = '{default: '0};
          oor_d      = '0;
          last_vld_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cycles_q       <= '{default: '0};
      entries_q      <= '{default: '0};
      oor_q          <= '0;
      last_vld_q     <= 1'b0;
      last_idx_q     <= '0;
      ptr_q          <= '0;
      dump_valid_q   <= 1'b0;
      dump_idx_q     <= '0;
      dump_cycles_q  <= '0;
      dump_entries_q <= '0;
      busy_q         <= 1'b0;
      dump_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycles_q       <= cycles_d;
      entries_q      <= entries_d;
      oor_q          <= oor_d;
      last_vld_q     <= last_vld_d;
      last_idx_q     <= last_idx_d;
      ptr_q          <= ptr_d;
      dump_valid_q   <= dump_valid_d;
      dump_idx_q     <= dump_idx_d;
      dump_cycles_q  <= dump_cycles_d;
      dump_entries_q <= dump_entries_d;
      busy_q         <= busy_d;
      dump_done_q    <= dump_done_d;
    end
  end

  assign dump_valid   = dump_valid_q;
  assign dump_idx     = dump_idx_q;
  assign dump_cycles  = dump_cycles_q;
  assign dump_entries = dump_entries_q;
  assign oor_count    = oor_q;
  assign busy         = busy_q;
  assign dump_done    = dump_done_q;

endmodule

// File: tb/tb_func_cycle_profiler.sv
// Scoreboard bench for func_cycle_profiler: three instances (32-bit clearing,
// 4-bit saturating clearing, 32-bit non-clearing) driven by shared stimulus.
module tb_func_cycle_profiler;

  localparam int NF = 64;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          reset, fn_valid, dump_req, dump_ready;
  logic [IW-1:0] fn_idx;

  logic          dv [3];
  logic [IW-1:0] di [3];
  logic [31:0]   dc [3];
  logic [31:0]   de [3];
  logic [31:0]   oc [3];
  logic          bz [3];
  logic          dd [3];
  logic [3:0]    s_dc, s_de, s_oc;

  always #5 clk = ~clk;

  func_cycle_profiler #(.NUM_FUNCS(NF), .IDX_W(IW), .CNT_W(32), .CLEAR_ON_DUMP(1)) u_main (
    .clk(clk), .reset(reset), .fn_valid(fn_valid), .fn_idx(fn_idx), .dump_req(dump_req),
    .dump_valid(dv[0]), .dump_ready(dump_ready), .dump_idx(di[0]), .dump_cycles(dc[0]),
    .dump_entries(de[0]), .oor_count(oc[0]), .busy(bz[0]), .dump_done(dd[0]));

  func_cycle_profiler #(.NUM_FUNCS(NF), .IDX_W(IW), .CNT_W(4), .CLEAR_ON_DUMP(1)) u_sat (
    .clk(clk), .reset(reset), .fn_valid(fn_valid), .fn_idx(fn_idx), .dump_req(dump_req),
    .dump_valid(dv[1]), .dump_ready(dump_ready), .dump_idx(di[1]), .dump_cycles(s_dc),
    .dump_entries(s_de), .oor_count(s_oc), .busy(bz[1]), .dump_done(dd[1]));

  func_cycle_profiler #(.NUM_FUNCS(NF), .IDX_W(IW), .CNT_W(32), .CLEAR_ON_DUMP(0)) u_keep (
    .clk(clk), .reset(reset), .fn_valid(fn_valid), .fn_idx(fn_idx), .dump_req(dump_req),
    .dump_valid(dv[2]), .dump_ready(dump_ready), .dump_idx(di[2]), .dump_cycles(dc[2]),
    .dump_entries(de[2]), .oor_count(oc[2]), .busy(bz[2]), .dump_done(dd[2]));

  assign dc[1] = 32'(s_dc);
  assign de[1] = 32'(s_de);
  assign oc[1] = 32'(s_oc);

  typedef struct {
    int              inst;
    int              idx;
    longint unsigned cyc;
    longint unsigned ent;
  } beat_t;

  beat_t           sb[$];
  longint unsigned m_cyc [3][NF];
  longint unsigned m_ent [3][NF];
  longint unsigned m_oor [3];
  longint unsigned m_max [3];
  bit              m_lv  [3];
  int              m_li  [3];
  bit              m_clr [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int f = 0; f < NF; f++) begin
        m_cyc[i][f] = 0;
        m_ent[i][f] = 0;
      end
      m_oor[i] = 0;
      m_lv[i]  = 1'b0;
      m_li[i]  = 0;
    end
  endtask

  task automatic model_sample(input bit v, input int idx);
    if (v) begin
      for (int i = 0; i < 3; i++) begin
        if (idx < NF) begin
          if (m_cyc[i][idx] < m_max[i]) m_cyc[i][idx]++;
          if (!m_lv[i] || idx != m_li[i]) begin
            if (m_ent[i][idx] < m_max[i]) m_ent[i][idx]++;
          end
          m_li[i] = idx;
          m_lv[i] = 1'b1;
        end else begin
          if (m_oor[i] < m_max[i]) m_oor[i]++;
          m_lv[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic sample(input bit v, input int idx);
    @(negedge clk);
    fn_valid = v;
    fn_idx   = IW'(idx);
    model_sample(v, idx);
  endtask

  // reset_at >= 0 asserts reset when that beat index is presented.
  task automatic dump(input bit toggle, input bit noise, input int reset_at);
    int    k;
    bit    fin;
    bit    stall [3];
    int    ndone [3];
    logic [IW-1:0] h_idx [3];
    logic [31:0]   h_cyc [3];
    logic [31:0]   h_ent [3];
    beat_t e;
    @(negedge clk);
    fn_valid   = 1'b0;
    dump_req   = 1'b1;
    dump_ready = 1'b1;
    for (int b = 0; b < NF; b++)
      for (int i = 0; i < 3; i++) begin
        e.inst = i; e.idx = b; e.cyc = m_cyc[i][b]; e.ent = m_ent[i][b];
        sb.push_back(e);
      end
    for (int i = 0; i < 3; i++) begin stall[i] = 1'b0; ndone[i] = 0; end
    k   = 0;
    fin = 1'b0;
    while (!fin && k < 2000) begin
      @(negedge clk);
      dump_req   = noise ? 1'($urandom) : 1'b0;
      fn_valid   = noise ? 1'($urandom) : 1'b0;
      fn_idx     = IW'($urandom);
      dump_ready = toggle ? (k % 3 == 0) : 1'b1;
      if (k == 0) check("busy_in_dump", 64'(bz[0]), 64'd1);
      for (int i = 0; i < 3; i++) if (dd[i]) ndone[i]++;
      if (dd[0]) begin
        fin      = 1'b1;
        fn_valid = 1'b0;
        dump_req = 1'b0;
        if (!toggle) check("done_latency", 64'(k + 1), 64'(NF + 1));
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (dv[i]) begin
            if (stall[i]) begin
              check($sformatf("hold_idx_i%0d", i), 64'(di[i]), 64'(h_idx[i]));
              check($sformatf("hold_cyc_i%0d", i), 64'(dc[i]), 64'(h_cyc[i]));
              check($sformatf("hold_ent_i%0d", i), 64'(de[i]), 64'(h_ent[i]));
            end
            if (dump_ready) begin
              stall[i] = 1'b0;
              if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
              end else begin
                e = sb.pop_front();
                check("beat_inst", 64'(i), 64'(e.inst));
                check($sformatf("beat_idx_i%0d", i), 64'(di[i]), 64'(e.idx));
                check($sformatf("beat%0d_cyc_i%0d", e.idx, i), 64'(dc[i]), 64'(e.cyc));
                check($sformatf("beat%0d_ent_i%0d", e.idx, i), 64'(de[i]), 64'(e.ent));
              end
            end else begin
              stall[i] = 1'b1;
              h_idx[i] = di[i]; h_cyc[i] = dc[i]; h_ent[i] = de[i];
            end
          end
        end
        if (reset_at >= 0 && dv[0] && int'(di[0]) == reset_at) begin
          reset = 1'b1;
          @(negedge clk);
          for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_mid_valid_i%0d", i), 64'(dv[i]), 64'd0);
            check($sformatf("rst_mid_busy_i%0d", i), 64'(bz[i]), 64'd0);
            check($sformatf("rst_mid_oor_i%0d", i), 64'(oc[i]), 64'd0);
          end
          reset = 1'b0;
          sb.delete();
          model_reset();
          return;
        end
      end
      k++;
    end
    if (!fin) check("dump_timeout", 64'd0, 64'd1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("done_count_i%0d", i), 64'(ndone[i]), 64'd1);
      check($sformatf("done_drop_i%0d", i), 64'(dd[i]), 64'd0);
      check($sformatf("busy_drop_i%0d", i), 64'(bz[i]), 64'd0);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 3; i++) begin
      if (m_clr[i]) begin
        for (int f = 0; f < NF; f++) begin m_cyc[i][f] = 0; m_ent[i][f] = 0; end
        m_oor[i] = 0;
        m_lv[i]  = 1'b0;
      end
    end
  endtask

  initial begin
    m_max[0] = 64'hFFFF_FFFF; m_max[1] = 64'd15; m_max[2] = 64'hFFFF_FFFF;
    m_clr[0] = 1'b1;          m_clr[1] = 1'b1;   m_clr[2] = 1'b0;
    model_reset();
    reset = 1'b1; fn_valid = 1'b0; fn_idx = '0; dump_req = 1'b0; dump_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(dv[0]), 64'd0);
    check("rst_idx",   64'(di[0]), 64'd0);
    check("rst_cyc",   64'(dc[0]), 64'd0);
    check("rst_ent",   64'(de[0]), 64'd0);
    check("rst_oor",   64'(oc[0]), 64'd0);
    check("rst_busy",  64'(bz[0]), 64'd0);
    check("rst_done",  64'(dd[0]), 64'd0);
    reset = 1'b0;

    // Basic residency/entry counting.
    foreach (sb[i]) ;
    sample(1, 3); sample(1, 3); sample(1, 3); sample(1, 5); sample(1, 5); sample(1, 3);
    sample(0, 0);
    check("seq_cyc3_model", m_cyc[0][3], 64'd4);
    check("seq_ent3_model", m_ent[0][3], 64'd2);
    dump(1'b0, 1'b0, -1);

    // Gap keeps last index; out-of-range breaks it.
    sample(1, 7);
    repeat (4) sample(0, 7);
    sample(1, 7); sample(1, 70); sample(1, 7);
    sample(0, 0);
    @(negedge clk);
    check("oor_live_main", 64'(oc[0]), m_oor[0]);
    check("oor_live_keep", 64'(oc[2]), m_oor[2]);
    check("ent7_model", m_ent[0][7], 64'd2);
    dump(1'b1, 1'b1, -1);

    // Saturation of the 4-bit instance.
    repeat (20) sample(1, 2);
    sample(0, 0);
    dump(1'b0, 1'b0, -1);

    // Second dump with no activity: cleared vs retained.
    dump(1'b0, 1'b0, -1);

    // Reset in the middle of a dump, then a clean dump.
    sample(1, 70); sample(1, 9); sample(0, 0);
    @(negedge clk);
    check("oor_pre_reset", 64'(oc[0]), m_oor[0]);
    dump(1'b0, 1'b0, 10);
    dump(1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/func_cycle_profiler.md
Name: func_cycle_profiler

Overview:
- Downstream consumer of the PC-to-function lookup stage in the pipelined RISC-V bench.
- Takes the per-cycle function index from that stage and accumulates two counts per function: cycles resident and entries (calls/transitions in).
- On request, streams the accumulated table out over a valid/ready port to the bench logger, then optionally clears it.
- Written synthesizable so it can also sit in the FPGA debug build.

Parameters:
- NUM_FUNCS, 64, number of table entries; legal fn_idx range 0..NUM_FUNCS-1.
- IDX_W, 6, width of fn_idx and dump_idx; must satisfy 2**IDX_W >= NUM_FUNCS.
- CNT_W, 32, width of every counter.
- CLEAR_ON_DUMP, 1, 1 = zero all counters after a completed dump; 0 = keep them.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fn_valid  in  1  fn_idx is valid this cycle (the lookup stage has a result and the pipeline is not flushing).
- fn_idx  in  IDX_W  function index of the current execute-stage PC.
- dump_req  in  1  start a table dump; sampled only in IDLE.
- dump_valid  out  1  dump beat is valid.
- dump_ready  in  1  consumer accepts the current beat.
- dump_idx  out  IDX_W  index of the current beat.
- dump_cycles  out  CNT_W  cycle count for dump_idx.
- dump_entries  out  CNT_W  entry count for dump_idx.
- oor_count  out  CNT_W  count of valid samples whose fn_idx is >= NUM_FUNCS; live value.
- busy  out  1  high while in DUMP or DONE.
- dump_done  out  1  one-cycle pulse when the last beat has been accepted.

Behaviour:
- States: IDLE, DUMP, DONE.
- Reset, at any time including mid-dump:
  - state = IDLE.
  - All cycle, entry and oor counters = 0.
  - last_vld = 0, last_idx = 0.
  - Outputs: dump_valid = 0, dump_idx = 0, dump_cycles = 0, dump_entries = 0, busy = 0, dump_done = 0, oor_count = 0.
- IDLE, counting:
  - Each cycle with fn_valid = 1 and fn_idx < NUM_FUNCS: cycles[fn_idx] += 1.
  - Entry rule: if last_vld = 0 or fn_idx != last_idx, also entries[fn_idx] += 1. Then last_idx = fn_idx and last_vld = 1.
  - fn_valid = 0 cycles change nothing. last_vld stays set, so a gap followed by the same index is not a new entry.
  - Each cycle with fn_valid = 1 and fn_idx >= NUM_FUNCS: oor_count += 1. last_vld is cleared, so the next in-range sample counts as an entry.
  - All counters saturate at 2**CNT_W-1 and never wrap.
- IDLE -> DUMP: on dump_req = 1.
  - A fn_valid sample in the same cycle is still counted.
  - The beat pointer is set to 0.
- DUMP:
  - fn_valid and fn_idx are ignored; no counter changes.
  - dump_valid = 1 from the first DUMP cycle, i.e. one cycle after dump_req was sampled.
  - dump_idx, dump_cycles and dump_entries are registered and held stable while dump_valid = 1 and dump_ready = 0.
  - A beat transfers on dump_valid & dump_ready. The next beat is presented the following cycle, giving at most 1 beat per cycle with dump_ready tied high.
  - dump_req during DUMP is ignored.
  - When beat NUM_FUNCS-1 transfers: dump_valid = 0 the next cycle and state goes to DONE.
- DONE, exactly one cycle:
  - dump_done = 1.
  - If CLEAR_ON_DUMP = 1: all cycle, entry and oor counters = 0 and last_vld = 0.
  - Samples in this cycle are ignored.
  - Next state is IDLE; busy drops in that IDLE cycle.
- busy = 1 in DUMP and DONE.
- Dump latency with dump_ready tied high: dump_done pulses NUM_FUNCS+1 cycles after the cycle in which dump_req was sampled.

Test Plan:
- Reset, then fn_valid with idx sequence 3,3,3,5,5,3 -> dump shows idx3 cycles=4 entries=2, idx5 cycles=2 entries=1, all other entries 0.
- idx 7, fn_valid low for 4 cycles, idx 7 again -> idx7 cycles=2 entries=1. Then idx 70 (NUM_FUNCS=64) followed by idx 7 -> oor_count=1, idx7 entries=2.
- CNT_W=4, idx 2 held valid for 20 cycles -> dump_cycles for idx2 = 15 (saturated), entries=1.
- dump_req with dump_ready toggling 1,0,0,1,... -> every beat held stable while stalled. All 64 beats arrive in order 0..63 with no duplicates; dump_done pulses once. fn_valid driven during the dump has no effect.
- CLEAR_ON_DUMP=1: dump, then dump again with no activity -> all zeros on the second dump. With CLEAR_ON_DUMP=0 -> the second dump equals the first.
- Assert reset during beat 10 of a dump -> the next cycle has dump_valid=0, busy=0, oor_count=0; a subsequent dump returns all zeros.
